// File: rtl/jt053246_pkg.sv
// Shared types and sizes for the 053246 sprite ROM arbiter.
// State encoding, ROM word-address width and tile-row width.
package jt053246_pkg;

  localparam int ROM_AW = 21;
  localparam int ROW_W  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW0,
    ST_GAP0,
    ST_DRAW1,
    ST_HOLD,
    ST_CPU,
    ST_GAP
  } state_t;

endpackage

// File: rtl/jt053246_romarb.sv
// Sprite ROM port arbiter: tile-row fetches for the drawer
// and CPU read-back share one ROM port.
module jt053246_romarb
  import jt053246_pkg::*;
#(
  parameter int STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dr_start,
  input  logic [15:0]       code,
  input  logic [3:0]        ysub,
  input  logic              vflip,
  input  logic              hflip,
  output logic              dr_busy,
  input  logic              rmrd_req,
  input  logic [20:0]       rmrd_addr,
  output logic [15:0]       rmrd_data,
  output logic              rmrd_ok,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_cs,
  input  logic              rom_ok,
  input  logic [31:0]       rom_data,
  output logic [ROW_W-1:0]  pxl_data,
  output logic              pxl_hflip,
  output logic              pxl_valid,
  input  logic              pxl_ready
);

  state_t      r_st;
  logic        r_dpend;
  logic        r_cpend;
  logic        r_ghold;
  logic [15:0] r_code;
  logic [3:0]  r_row;
  logic [20:0] r_caddr;
  logic [7:0]  r_starve;

  logic w_ok;
  logic w_dacc;
  logic w_cacc;
  logic w_starved;

  assign rom_cs = r_st inside {ST_DRAW0, ST_DRAW1, ST_CPU};
  assign w_ok   = rom_cs & rom_ok;

  // GAP with r_ghold is the settle cycle before a row is handed over
  assign dr_busy = r_dpend
                 | (r_st inside {ST_DRAW0, ST_GAP0, ST_DRAW1, ST_HOLD})
                 | (r_st == ST_GAP && r_ghold);

  assign w_dacc    = dr_start & ~dr_busy;
  assign w_cacc    = rmrd_req & ~r_cpend & (r_st != ST_CPU);
  assign w_starved = r_starve == 8'(STARVE);

  always_comb begin
    rom_addr = '0;
    unique case (1'b1)
      r_st == ST_DRAW0: rom_addr = {r_code, r_row, 1'b0};
      r_st == ST_DRAW1: rom_addr = {r_code, r_row, 1'b1};
      r_st == ST_CPU:   rom_addr = {1'b0, r_caddr[20:1]};
      default:          rom_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= ST_IDLE;
      r_dpend   <= 1'b0;
      r_cpend   <= 1'b0;
      r_ghold   <= 1'b0;
      r_code    <= '0;
      r_row     <= '0;
      r_caddr   <= '0;
      r_starve  <= '0;
      rmrd_data <= '0;
      rmrd_ok   <= 1'b0;
      pxl_data  <= '0;
      pxl_hflip <= 1'b0;
      pxl_valid <= 1'b0;
    end else begin
      rmrd_ok <= 1'b0;
      if (w_dacc) begin
        r_dpend   <= 1'b1;
        r_code    <= code;
        r_row     <= ysub ^ {4{vflip}};
        pxl_hflip <= hflip;
      end
      if (w_cacc) begin
        r_cpend <= 1'b1;
        r_caddr <= rmrd_addr;
      end
      if (!r_cpend) r_starve <= '0;
      unique case (r_st)
        ST_IDLE: begin
          if (r_cpend && (!r_dpend || w_starved)) begin
            r_cpend  <= 1'b0;
            r_starve <= '0;
            r_st     <= ST_CPU;
          end else if (r_dpend) begin
            r_dpend <= 1'b0;
            if (r_cpend) r_starve <= r_starve + 8'd1;
            r_st <= ST_DRAW0;
          end
        end
        ST_DRAW0: begin
          if (w_ok) begin
            pxl_data[31:0] <= rom_data;
            r_st           <= ST_GAP0;
          end
        end
        ST_GAP0: r_st <= ST_DRAW1;
        ST_DRAW1: begin
          if (w_ok) begin
            pxl_data[63:32] <= rom_data;
            r_ghold         <= 1'b1;
            r_st            <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_ghold) begin
            r_ghold   <= 1'b0;
            pxl_valid <= 1'b1;
            r_st      <= ST_HOLD;
          end else begin
            r_st <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (pxl_ready) begin
            pxl_valid <= 1'b0;
            r_st      <= ST_GAP;
          end
        end
        ST_CPU: begin
          if (w_ok) begin
            rmrd_data <= r_caddr[0] ? rom_data[31:16] : rom_data[15:0];
            rmrd_ok   <= 1'b1;
            r_st      <= ST_GAP;
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  // the scanner must wait for dr_busy low before starting a job
  a_start_legal: assert property (
    @(posedge clk) disable iff (!rst_n) !(dr_start && dr_busy));

endmodule

// File: tb/tb_jt053246_romarb.sv
// Directed bench for jt053246_romarb with a small ROM model
// answering on the second cycle of each rom_cs request.
module tb_jt053246_romarb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dr_start;
  logic [15:0] code;
  logic [3:0]  ysub;
  logic        vflip;
  logic        hflip;
  logic        dr_busy;
  logic        rmrd_req;
  logic [20:0] rmrd_addr;
  logic [15:0] rmrd_data;
  logic        rmrd_ok;
  logic [20:0] rom_addr;
  logic        rom_cs;
  logic        rom_ok;
  logic [31:0] rom_data;
  logic [63:0] pxl_data;
  logic        pxl_hflip;
  logic        pxl_valid;
  logic        pxl_ready;

  int checks = 0;
  int errors = 0;
  int ccnt = 0;
  logic        cs_prev = 1'b0;
  logic [20:0] gq[$];
  logic [20:0] gexp[13];

  jt053246_romarb #(.STARVE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .dr_start(dr_start), .code(code), .ysub(ysub),
    .vflip(vflip), .hflip(hflip), .dr_busy(dr_busy),
    .rmrd_req(rmrd_req), .rmrd_addr(rmrd_addr),
    .rmrd_data(rmrd_data), .rmrd_ok(rmrd_ok),
    .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_ok(rom_ok), .rom_data(rom_data),
    .pxl_data(pxl_data), .pxl_hflip(pxl_hflip),
    .pxl_valid(pxl_valid), .pxl_ready(pxl_ready)
  );

  always #5 clk = ~clk;

  // ROM: ok on the 2nd cycle of a request, data derived from address
  always @(posedge clk) begin
    if (!rom_cs || rom_ok) ccnt <= 0;
    else ccnt <= ccnt + 1;
  end
  assign rom_ok   = rom_cs && (ccnt == 1);
  assign rom_data = (rom_addr == 21'h000001) ? 32'hAABBCCDD
                                             : {11'h5A5, rom_addr};

  // log the address of every new ROM request
  always @(negedge clk) begin
    if (rom_cs && !cs_prev) gq.push_back(rom_addr);
    cs_prev = rom_cs;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_draw(input logic [15:0] c, input logic [3:0] y,
                          input logic vf, input logic hf,
                          input logic [20:0] a0, input logic [63:0] d);
    dr_start = 1'b1; code = c; ysub = y; vflip = vf; hflip = hf;
    tick;
    dr_start = 1'b0; code = 16'hDEAD; ysub = 4'hA;
    vflip = 1'b0; hflip = 1'b0;
    chk("busy_rise", 64'(dr_busy), 64'd1);
    chk("cs_c1", 64'(rom_cs), 64'd0);
    tick;
    chk("addr_w0", 64'({rom_cs, rom_addr}), 64'({1'b1, a0}));
    repeat (3) tick;
    chk("addr_w1", 64'({rom_cs, rom_addr}), 64'({1'b1, a0 | 21'd1}));
    repeat (2) tick;
    chk("valid_c7", 64'(pxl_valid), 64'd0);
    tick;
    chk("valid_c8", 64'({pxl_valid, dr_busy, rom_cs}), 64'b110);
    chk("pxl_data", pxl_data, d);
    chk("pxl_hflip", 64'(pxl_hflip), 64'(hf));
    pxl_ready = 1'b1;
    tick;
    pxl_ready = 1'b0;
    chk("after_xfer", 64'({pxl_valid, dr_busy}), 64'b00);
    tick;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; dr_start = 1'b0; code = '0; ysub = '0;
    vflip = 1'b0; hflip = 1'b0; rmrd_req = 1'b0;
    rmrd_addr = '0; pxl_ready = 1'b0;
    gexp = '{21'h002000, 21'h002001, 21'h002020, 21'h002021,
             21'h002040, 21'h002041, 21'h002060, 21'h002061,
             21'h000001, 21'h002080, 21'h002081, 21'h0020A0,
             21'h0020A1};
    #1;
    chk("rst_flags", 64'({dr_busy, rom_cs, pxl_valid, pxl_hflip, rmrd_ok}),
        64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);
    chk("rst_pxl", pxl_data, 64'd0);
    chk("rst_rmrd", 64'(rmrd_data), 64'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // plain draw, then vertically flipped row
    run_draw(16'h1234, 4'd3, 1'b0, 1'b0, 21'h024686,
             64'hB4A24687_B4A24686);
    run_draw(16'h1234, 4'd3, 1'b1, 1'b1, 21'h024698,
             64'hB4A24699_B4A24698);

    // CPU read-back, upper halfword
    rmrd_req = 1'b1; rmrd_addr = 21'h000003;
    tick;
    rmrd_req = 1'b0; rmrd_addr = 21'h1FFFFF;
    chk("cpu_ok_c1", 64'(rmrd_ok), 64'd0);
    tick;
    chk("cpu_addr", 64'({rom_cs, rom_addr}), 64'({1'b1, 21'h000001}));
    chk("cpu_busy", 64'(dr_busy), 64'd0);
    tick; tick;
    chk("cpu_ok", 64'({rmrd_ok, rmrd_data}), 64'({1'b1, 16'hAABB}));
    tick;
    chk("cpu_ok_pulse", 64'(rmrd_ok), 64'd0);
    tick;

    // starvation: CPU waits behind back-to-back draws
    gq.delete();
    pxl_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dr_start = 1'b1; code = 16'(16'h0100 + i);
      ysub = 4'd0; vflip = 1'b0; hflip = 1'b0;
      if (i == 0) begin
        rmrd_req = 1'b1; rmrd_addr = 21'h000003;
      end
      tick;
      dr_start = 1'b0; rmrd_req = 1'b0;
      n = 0;
      while (dr_busy && n < 60) begin
        tick;
        n++;
      end
      chk("strv_wait", 64'(n < 60), 64'd1);
    end
    pxl_ready = 1'b0;
    tick; tick;
    chk("strv_count", 64'(gq.size()), 64'd13);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("strv_grant%0d", i),
          64'((i < gq.size()) ? gq[i] : 21'h1FFFFF), 64'(gexp[i]));
    end

    // backpressure with a CPU read queued behind the held row
    dr_start = 1'b1; code = 16'hBEEF; ysub = 4'd5;
    vflip = 1'b0; hflip = 1'b0;
    tick;
    dr_start = 1'b0;
    repeat (7) tick;
    chk("bp_valid", 64'(pxl_valid), 64'd1);
    chk("bp_data", pxl_data, 64'hB4B7DDEB_B4B7DDEA);
    rmrd_req = 1'b1; rmrd_addr = 21'h000002;
    tick;
    rmrd_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold_flags", 64'({pxl_valid, dr_busy, rom_cs, rmrd_ok}),
          64'b1100);
      chk("bp_hold_data", pxl_data, 64'hB4B7DDEB_B4B7DDEA);
      tick;
    end
    pxl_ready = 1'b1;
    tick;
    pxl_ready = 1'b0;
    chk("bp_xfer", 64'({pxl_valid, dr_busy}), 64'b00);
    tick; tick;
    chk("bp_cpu_addr", 64'({rom_cs, rom_addr}), 64'({1'b1, 21'h000001}));
    tick; tick;
    chk("bp_cpu_ok", 64'({rmrd_ok, rmrd_data}), 64'({1'b1, 16'hCCDD}));
    tick; tick;

    // reset in the middle of the second draw word
    dr_start = 1'b1; code = 16'h00FF; ysub = 4'd0;
    vflip = 1'b1; hflip = 1'b1;
    tick;
    dr_start = 1'b0;
    repeat (4) tick;
    chk("mid_draw1", 64'({rom_cs, rom_addr}), 64'({1'b1, 21'h001FFF}));
    rst_n = 1'b0;
    #1;
    chk("mrst_flags",
        64'({dr_busy, rom_cs, pxl_valid, pxl_hflip, rmrd_ok}), 64'd0);
    chk("mrst_addr", 64'(rom_addr), 64'd0);
    chk("mrst_pxl", pxl_data, 64'd0);
    chk("mrst_rmrd", 64'(rmrd_data), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    run_draw(16'h00FF, 4'd0, 1'b1, 1'b1, 21'h001FFE,
             64'hB4A01FFF_B4A01FFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
